bsram_dma: RTL

//  Arbiter and DMA sequencer in front of one bsram instance (1 read port, 1 write port, 16-bit words).
//  The CPU has absolute priority on both ports. A built-in DMA engine uses only the idle cycles.
//  DMA modes: block COPY (src->dst) and block FILL (constant->dst).

---
 rtl/bsram_dma.sv | 84 ++++++++
 1 files changed

// File: rtl/bsram_dma.sv
// bsram_dma: CPU-priority port arbiter with a COPY/FILL DMA engine in front of one bsram
module bsram_dma #(
    parameter int WIDTH = 13
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cpu_re,
    input  logic [WIDTH-1:0] cpu_raddr,
    output logic [15:0]      cpu_rdata,
    output logic             cpu_rvalid,
    input  logic             cpu_we,
    input  logic [WIDTH-1:0] cpu_waddr,
    input  logic [15:0]      cpu_wdata,
    input  logic             dma_start,
    input  logic             dma_mode,
    input  logic [WIDTH-1:0] dma_src,
    input  logic [WIDTH-1:0] dma_dst,
    input  logic [WIDTH-1:0] dma_len,
    input  logic [15:0]      dma_fill,
    output logic             dma_busy,
    output logic             dma_done,
    output logic [WIDTH-1:0] mem_dout_addr,
    input  logic [15:0]      mem_dout,
    output logic             we,
    output logic [WIDTH-1:0] mem_din_addr,
    output logic [15:0]      mem_din
);
    typedef enum logic [2:0] {IDLE, RD, CAP, WR, DONE} state_t;
    state_t state, state_nx;
    logic mode;
    logic [WIDTH-1:0] src, dst, len, idx, idx_inc;
    logic [15:0] fill, hold;
    logic dma_rd, dma_wr;
    assign idx_inc = idx + WIDTH'(1);
    // DMA only takes a port the CPU leaves idle; reset suppresses a pending write at once
    assign dma_rd = state == RD && !cpu_re;
    assign dma_wr = state == WR && !cpu_we && !reset;
    assign mem_dout_addr = dma_rd ? src + idx : cpu_raddr;
    assign cpu_rdata = mem_dout;
    assign we = cpu_we | dma_wr;
    assign mem_din_addr = cpu_we ? cpu_waddr : dst + idx;
    assign mem_din = cpu_we ? cpu_wdata : (mode ? fill : hold);
    assign dma_busy = state == RD || state == CAP || state == WR;
    assign dma_done = state == DONE;
    // next-state: stall in RD/WR while the CPU owns the port
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (dma_start) state_nx = (dma_len == '0) ? DONE : (dma_mode ? WR : RD);
            RD:   if (!cpu_re) state_nx = CAP;
            CAP:  state_nx = WR;
            WR:   if (!cpu_we) state_nx = (idx_inc == len) ? DONE : (mode ? WR : RD);
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end
    // state, command latch, copy hold register and word index
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cpu_rvalid <= 1'b0;
            mode <= 1'b0;
            src <= '0;
            dst <= '0;
            len <= '0;
            idx <= '0;
            fill <= '0;
            hold <= '0;
        end else begin
            state <= state_nx;
            cpu_rvalid <= cpu_re;
            if (state == IDLE && dma_start) begin
                mode <= dma_mode;
                src <= dma_src;
                dst <= dma_dst;
                len <= dma_len;
                fill <= dma_fill;
                idx <= '0;
            end
            if (state == CAP) hold <= mem_dout;
            if (dma_wr) idx <= idx_inc;
        end
    end
endmodule
